// File: rtl/tx_byte_fifo.sv
// Byte FIFO between the event counter and the UART transmitter; re-issues bytes as
// single-cycle tx_start pulses spaced by a frame-length timer (the UART has no busy).
module tx_byte_fifo #(
  parameter int DEPTH       = 16,
  parameter int CLK_PER_BIT = 868,
  parameter int FRAME_BITS  = 10,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic [7:0]               dout,
  output logic                     tx_start,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PACE = CLK_PER_BIT * FRAME_BITS + GAP_CYCLES;
  localparam int TW   = (PACE > 2) ? $clog2(PACE) : 1;

  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(PACE - 2);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [TW-1:0] timer;
  state_t        state, state_nxt;
  logic          pop, push;
  logic [AW:0]   level_nxt;

  // A full FIFO still accepts a write on the edge that pops, since a slot frees.
  always_comb begin
    pop  = (state == S_IDLE) && (level != '0);
    push = din_valid && ((level != LVL_FULL) || pop);
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_WAIT;
      S_WAIT:  if (timer == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset; occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      timer    <= '0;
      level    <= '0;
      dout     <= 8'h00;
      tx_start <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      busy  <= !((state_nxt == S_IDLE) && (level_nxt == '0));
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (din_valid && !push) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          tx_start <= pop;
          if (pop) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_ONE;
            timer  <= TMR_LOAD;
          end
        end
        S_WAIT: begin
          tx_start <= 1'b0;
          if (timer != '0) timer <= timer - TMR_ONE;
        end
        default: tx_start <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_byte_fifo.sv
// Randomized + directed bench for tx_byte_fifo: a queue-based reference model predicts
// each issued byte and its edge; a monitor checks pulses and status every cycle.
module tb_tx_byte_fifo;
  localparam int DEPTH = 4, CPB = 4, FB = 10, GAP = 2;
  localparam int PACE = CPB * FB + GAP;

  logic       clk = 1'b0, rstn = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_start, full, empty, overflow, busy;
  logic [2:0] level;

  tx_byte_fifo #(.DEPTH(DEPTH), .CLK_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .dout(dout),
    .tx_start(tx_start), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int e; } exp_t;

  int         checks = 0, failures = 0;
  logic [7:0] mq[$];
  exp_t       expq[$];
  int         cyc = 0, next_issue = 0;
  bit         movf = 1'b0;
  logic [7:0] mdout = 8'h00;

  function automatic bit mbusy();
    return (mq.size() > 0) || (cyc < next_issue - 1);
  endfunction

  // Reference model: a byte leaves when the queue is non-empty and a frame slot is free.
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      mq.delete(); expq.delete();
      next_issue = 0; movf = 1'b0; mdout = 8'h00;
    end else begin
      cyc++;
      if (mq.size() > 0 && cyc >= next_issue) begin
        exp_t x;
        x.b = mq.pop_front();
        x.e = cyc;
        expq.push_back(x);
        mdout = x.b;
        next_issue = cyc + PACE;
      end
      if (din_valid) begin
        if (mq.size() < DEPTH) mq.push_back(din);
        else movf = 1'b1;
      end
    end
  end

  // Monitor: pulses against the scoreboard, status against the model.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (tx_start || (expq.size() > 0 && expq[0].e <= cyc)) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected: tx_start=%b dout=%h at edge %0d, want no pulse", tx_start, dout, cyc);
        end else begin
          exp_t x;
          x = expq.pop_front();
          if (tx_start !== 1'b1 || dout !== x.b || x.e != cyc) begin
            failures++;
            $display("FAIL tx_pulse: tx_start=%b dout=%h edge=%0d, want tx_start=1 dout=%h edge=%0d",
                     tx_start, dout, cyc, x.b, x.e);
          end
        end
      end
      checks++;
      if ({dout, level, full, empty, busy, overflow} !==
          {mdout, 3'(mq.size()), mq.size() == DEPTH, mq.size() == 0, mbusy(), movf}) begin
        failures++;
        $display("FAIL status: dout=%h lvl=%0d full=%b empty=%b busy=%b ovf=%b, want dout=%h lvl=%0d full=%b empty=%b busy=%b ovf=%b (edge %0d)",
                 dout, level, full, empty, busy, overflow, mdout, mq.size(), mq.size() == DEPTH,
                 mq.size() == 0, mbusy(), movf, cyc);
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    din = b; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || expq.size() > 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL drain_timeout: busy=%b pending=%0d, want busy=0 pending=0", busy, expq.size());
    end
  endtask

  task automatic reset_check();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({dout, tx_start, empty, full, level, overflow, busy} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: dout=%h tx=%b empty=%b full=%b lvl=%0d ovf=%b busy=%b, want 00 0 1 0 0 0 0",
               dout, tx_start, empty, full, level, overflow, busy);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({dout, tx_start, empty, full, level, overflow, busy} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_initial: dout=%h tx=%b empty=%b full=%b lvl=%0d ovf=%b busy=%b, want 00 0 1 0 0 0 0",
               dout, tx_start, empty, full, level, overflow, busy);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // single byte
    wr(8'hA5);
    wait_drain();

    // burst of four
    for (int i = 1; i <= 4; i++) wr(8'(i));
    wait_drain();

    // full FIFO, write lands on the popping edge
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
    n = 0;
    while (!(mq.size() == DEPTH && next_issue == cyc + 1) && n < 200) begin
      @(negedge clk); n++;
    end
    wr(8'h77);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_push: lvl=%0d ovf=%b full=%b, want lvl=4 ovf=0 full=1", level, overflow, full);
    end
    wait_drain();

    // wrap-around, writing only into free slots
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (level == 3'(DEPTH) && n < 200) begin
        @(negedge clk); n++;
      end
      wr(8'h20 + 8'(i));
    end
    wait_drain();

    // overflow
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: ovf=%b, want 1", overflow);
    end
    wait_drain();

    // reset mid-frame with two bytes queued
    for (int i = 0; i < 3; i++) wr(8'h50 + 8'(i));
    repeat (10) @(negedge clk);
    reset_check();
    repeat (60) @(negedge clk);
    wr(8'h3C);
    wait_drain();

    // randomized traffic: sparse then bursty
    for (int i = 0; i < 600; i++) begin
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 99) < ((i < 300) ? 3 : 30));
      @(negedge clk);
    end
    din_valid = 1'b0;
    wait_drain();

    checks++;
    if (expq.size() != 0 || mq.size() != 0) begin
      failures++;
      $display("FAIL final_empty: pending=%0d queued=%0d, want 0 0", expq.size(), mq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
